// File: rtl/keypad_debounce_encoder.sv
// keypad_debounce_encoder: synchronize, debounce and binary-encode a raw key vector with press strobe and multi-key detect
module keypad_debounce_encoder #(
   parameter int NUM_KEYS        = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MULTI_KEY_MODE  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [NUM_KEYS-1:0] kbd,
   output logic [CODE_W-1:0]   code,
   output logic                key_valid,
   output logic                key_pulse,
   output logic                multi_err
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE_WAIT} state_t;
   state_t              state_q, state_d;
   logic [NUM_KEYS-1:0] meta_q, ks_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   idx_q, idx_d, code_q, code_d, cand_idx;
   logic                pulse_q, pulse_d, multi_q, armed_q, armed_d;
   logic                any_key, multi, cand_ok, match;
   // candidate decode from the synchronized keys; lowest set index is used in both modes
   always_comb begin
      any_key  = |ks_q;
      multi    = |(ks_q & (ks_q - NUM_KEYS'(1)));
      cand_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (ks_q[i]) cand_idx = CODE_W'(i);
      cand_ok  = (MULTI_KEY_MODE != 0) ? any_key : (any_key && !multi);
      match    = cand_ok && (cand_idx == idx_q);
   end
   // next-state logic; armed drops when a key is seen while disabled so it cannot be accepted on en reassertion
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      code_d  = code_q;
      pulse_d = 1'b0;
      armed_d = !any_key || (armed_q && en);
      case (state_q)
         IDLE:
            if (en && armed_q && cand_ok) begin
               state_d = DEBOUNCE;
               idx_d   = cand_idx;
               cnt_d   = CNT_W'(1);
            end
         DEBOUNCE:
            if (!en || !match) state_d = IDLE;
            else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               code_d  = idx_q;
               pulse_d = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
         PRESSED:
            if (!en || !match) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         default: begin
            cnt_d   = any_key ? '0 : cnt_q + CNT_W'(1);
            state_d = (!any_key && cnt_d == CNT_MAX) ? IDLE : state_q;
         end
      endcase
   end
   // state, synchronizer and registered outputs with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         meta_q  <= '0;
         ks_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         code_q  <= '0;
         pulse_q <= 1'b0;
         multi_q <= 1'b0;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         meta_q  <= kbd;
         ks_q    <= meta_q;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         pulse_q <= pulse_d;
         multi_q <= multi;
         armed_q <= armed_d;
      end
   end
   assign code      = code_q;
   assign key_valid = (state_q == PRESSED);
   assign key_pulse = pulse_q;
   assign multi_err = multi_q;
endmodule
